// File: rtl/lcnt_pkg.sv
// Shared encodings for the sequential leading/trailing count block:
// operation modes and FSM states.
package lcnt_pkg;

    // Operation selected at acceptance.
    // Bit 1 selects a trailing count (bit-reverse), bit 0 counts ones (invert).
    typedef enum logic [1:0] {
        MODE_CLZ = 2'b00,
        MODE_CLO = 2'b01,
        MODE_CTZ = 2'b10,
        MODE_CTO = 2'b11
    } lcnt_mode_e;

    // Control FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } lcnt_state_e;

endpackage

// File: rtl/lcnt_prep.sv
// Operand preparation: turns every mode into a count of leading zeros.
// Trailing counts reverse the bit order; counts of ones invert the bits.
module lcnt_prep
    import lcnt_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] data,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] window
);

    logic [WIDTH-1:0] reversed;
    logic             do_reverse;
    logic             do_invert;

    assign do_reverse = (mode == MODE_CTZ) || (mode == MODE_CTO);
    assign do_invert  = (mode == MODE_CLO) || (mode == MODE_CTO);

    // Bit-reverse the operand so trailing bits become leading bits.
    always_comb begin
        reversed = '0;
        for (int i = 0; i < WIDTH; i++) begin
            reversed[i] = data[WIDTH-1-i];
        end
    end

    // Select reversal, then invert so the search is always for leading zeros.
    always_comb begin
        window = do_reverse ? reversed : data;
        if (do_invert) begin
            window = ~window;
        end
    end

endmodule

// File: rtl/lead_count_seq.sv
// Sequential CLZ/CLO/CTZ/CTO unit. Binary search over the prepared window,
// one level per cycle, result valid log2(WIDTH)+1 cycles after acceptance.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; in_ready depends only on state, out_valid is held with a stable
// result until out_ready is seen.
// Optional macro LCNT_EARLY_OUT_EN: all-match operands skip the search and
// complete one cycle after acceptance.
module lead_count_seq
    import lcnt_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int RES_W = 32
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  data,
    input  logic [1:0]        mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RES_W-1:0]  result,
    output logic              busy,
    output lcnt_state_e       dbg_state
);

    localparam int LVL_W = $clog2(WIDTH);
    localparam logic [LVL_W:0]   WIDTH_V = (LVL_W+1)'(WIDTH);
    localparam logic [LVL_W-1:0] LVL_TOP = LVL_W'(LVL_W - 1);
    localparam logic [LVL_W-1:0] LVL_ONE = LVL_W'(1);
    localparam logic [RES_W-1:0] RES_ALL = RES_W'(WIDTH);

    lcnt_state_e      state;
    logic [WIDTH-1:0] window;
    logic [LVL_W-1:0] level;
    logic [WIDTH-1:0] prep_window;

    logic [LVL_W:0]   step_sz;
    logic [LVL_W:0]   shr;
    logic             upper_zero;
    logic [WIDTH-1:0] win_next;
    logic [RES_W-1:0] res_next;

    lcnt_prep #(
        .WIDTH (WIDTH)
    ) u_prep (
        .data   (data),
        .mode   (mode),
        .window (prep_window)
    );

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    // One search step: test the upper 2^level bits, shift them out if zero.
    always_comb begin
        step_sz    = (LVL_W+1)'(1) << level;
        shr        = WIDTH_V - step_sz;
        upper_zero = ((window >> shr) == '0);
        win_next   = window;
        res_next   = result;
        if (upper_zero) begin
            win_next = window << step_sz;
            res_next = result | (RES_W'(1) << level);
        end
    end

    // Control FSM with registered window, level, result and out_valid.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            window    <= '0;
            level     <= '0;
        end else if (flush) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            window    <= '0;
            level     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        window <= prep_window;
                        result <= '0;
                        level  <= LVL_TOP;
`ifdef LCNT_EARLY_OUT_EN
                        if (prep_window == '0) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            result    <= RES_ALL;
                        end else begin
                            state <= RUN;
                        end
`else
                        state <= RUN;
`endif
                    end
                end
                RUN: begin
                    window <= win_next;
                    result <= res_next;
                    if (level == '0) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        // A still-zero MSB after the last step means no bit matched.
                        if (!win_next[WIDTH-1]) begin
                            result <= RES_ALL;
                        end
                    end else begin
                        level <= level - LVL_ONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lead_count_seq.sv
// Directed bench for lead_count_seq (WIDTH=32, RES_W=32).
module tb_lead_count_seq;
    import lcnt_pkg::*;

    logic        clk;
    logic        clrn;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] data;
    logic [1:0]  mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;
    lcnt_state_e dbg_state;

    int checks = 0;
    int errors = 0;

`ifdef LCNT_EARLY_OUT_EN
    localparam int EARLY = 1;
`else
    localparam int EARLY = 0;
`endif

    lead_count_seq #(
        .WIDTH (32),
        .RES_W (32)
    ) dut (
        .clk       (clk),
        .clrn      (clrn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data      (data),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operand for one cycle, then scramble data/mode.
    task automatic issue(input logic [31:0] d, input logic [1:0] m);
        data     = d;
        mode     = m;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        data     = $urandom;
        mode     = 2'($urandom_range(0, 3));
    endtask

    // Count cycles from acceptance (cycle 0) until out_valid, bounded.
    task automatic wait_valid(output int lat, output bit ok);
        lat = 1;
        ok  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        clrn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        data = '0; mode = 2'b00;
        #3;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || result !== 32'd0 || dbg_state !== IDLE) begin
            errors++;
            $display("FAIL reset_state: out_valid=%b busy=%b result=%0d state=%0d required 0 0 0 IDLE",
                     out_valid, busy, result, dbg_state);
        end
        tick(); tick();
        #2 clrn = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: in_ready=%b required 1", in_ready);
        end
    endtask

    typedef struct {
        logic [31:0] d;
        logic [1:0]  m;
        int          exp;
    } vec_t;

    task automatic test_vectors();
        vec_t vecs[10];
        int   lat, exp_lat;
        bit   ok;
        vecs[0] = '{32'hF100_0000, MODE_CLO, 4};
        vecs[1] = '{32'h0000_0000, MODE_CLZ, 32};
        vecs[2] = '{32'h0000_0100, MODE_CTZ, 8};
        vecs[3] = '{32'h0000_000F, MODE_CTO, 4};
        vecs[4] = '{32'h8000_0000, MODE_CLZ, 0};
        vecs[5] = '{32'hFFFF_FFFF, MODE_CLO, 32};
        vecs[6] = '{32'h0001_0000, MODE_CLZ, 15};
        vecs[7] = '{32'h0000_FFFF, MODE_CTO, 16};
        vecs[8] = '{32'h0000_0001, MODE_CTZ, 0};
        vecs[9] = '{32'hFFFF_FFFF, MODE_CTO, 32};
        for (int v = 0; v < 10; v++) begin
            exp_lat = (EARLY == 1 && vecs[v].exp == 32) ? 1 : 6;
            issue(vecs[v].d, vecs[v].m);
            wait_valid(lat, ok);
            checks++;
            if (!ok || lat != exp_lat) begin
                errors++;
                $display("FAIL vec%0d_latency: valid=%b latency=%0d required %0d", v, ok, lat, exp_lat);
            end
            checks++;
            if (result !== vecs[v].exp) begin
                errors++;
                $display("FAIL vec%0d_result: result=%0d required %0d", v, result, vecs[v].exp);
            end
            checks++;
            if (in_ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL vec%0d_done_flags: in_ready=%b busy=%b required 0 1", v, in_ready, busy);
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || dbg_state !== IDLE) begin
                errors++;
                $display("FAIL vec%0d_consume: out_valid=%b in_ready=%b state=%0d required 0 1 IDLE",
                         v, out_valid, in_ready, dbg_state);
            end
        end
    endtask

    task automatic test_hold();
        int lat;
        bit ok;
        int bad = 0;
        issue(32'h00F0_0000, MODE_CLZ);
        wait_valid(lat, ok);
        for (int i = 0; i < 10; i++) begin
            if (out_valid !== 1'b1 || result !== 32'd8 || in_ready !== 1'b0) bad++;
            tick();
        end
        checks++;
        if (!ok || bad != 0) begin
            errors++;
            $display("FAIL hold_stable: valid=%b unstable_cycles=%0d result=%0d required 0 cycles result 8",
                     ok, bad, result);
        end
        out_ready = 1'b1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold_handshake_ready: in_ready=%b required 0", in_ready);
        end
        tick();
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_release: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_flush();
        int lat;
        bit ok;
        int seen = 0;
        issue(32'h0001_0000, MODE_CLZ);
        tick(); tick();
        flush    = 1'b1;
        in_valid = 1'b1;
        data     = 32'h0000_0000;
        mode     = MODE_CLZ;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (dbg_state !== IDLE || out_valid !== 1'b0 || result !== 32'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_state: state=%0d out_valid=%b result=%0d in_ready=%b required IDLE 0 0 1",
                     dbg_state, out_valid, result, in_ready);
        end
        for (int i = 0; i < 10; i++) begin
            if (out_valid !== 1'b0 || busy !== 1'b0) seen++;
            tick();
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL flush_no_output: active_cycles=%0d required 0", seen);
        end
        issue(32'h0000_0F00, MODE_CTZ);
        wait_valid(lat, ok);
        checks++;
        if (!ok || lat != 6 || result !== 32'd8) begin
            errors++;
            $display("FAIL flush_next_op: valid=%b latency=%0d result=%0d required 6 8", ok, lat, result);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int seen = 0;
        issue(32'h0000_0001, MODE_CLZ);
        tick(); tick();
        #1 clrn = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || result !== 32'd0 || dbg_state !== IDLE) begin
            errors++;
            $display("FAIL rst_async: out_valid=%b busy=%b result=%0d state=%0d required 0 0 0 IDLE",
                     out_valid, busy, result, dbg_state);
        end
        #2 clrn = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_in_ready: in_ready=%b required 1", in_ready);
        end
        for (int i = 0; i < 10; i++) begin
            if (out_valid !== 1'b0) seen++;
            tick();
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL rst_no_stale: valid_cycles=%0d required 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_hold();
        test_flush();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lead_count_seq.md
LEAD_COUNT_SEQ -- requirements
Module: lead_count_seq

Interface
REQ-001 Parameter WIDTH, default 32, operand width; power of two, 8..64.
REQ-002 Parameter RES_W, default 32, result width; RES_W >= log2(WIDTH)+1.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 clrn  input  1  reset, asynchronous, active-low.
REQ-005 flush  input  1  synchronous abort of any operation in flight.
REQ-006 in_valid  input  1  operand and mode present.
REQ-007 in_ready  output  1  block accepts operand this cycle.
REQ-008 data  input  WIDTH  operand.
REQ-009 mode  input  2  00 CLZ, 01 CLO, 10 CTZ, 11 CTO.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer takes result.
REQ-012 result  output  RES_W  count, zero-extended.
REQ-013 busy  output  1  high in RUN or DONE.

Function
REQ-014 FSM states: IDLE, RUN, DONE; in_ready SHALL equal (state==IDLE).
REQ-015 Accept when in_valid & in_ready: capture window = data, bit-reversed for CTZ/CTO, then inverted for CLO/CTO; clear result; set level = log2(WIDTH)-1; go to RUN.
REQ-016 RUN, one level per cycle: if upper 2^level bits of window are all zero, set result bit[level] and shift window left by 2^level; decrement level.
REQ-017 RUN at level 0: if window[WIDTH-1]==0 after the step, force result = WIDTH (all-match); go to DONE.
REQ-018 Latency: acceptance in cycle 0; out_valid high from cycle log2(WIDTH)+1 (6 for WIDTH=32).
REQ-019 DONE: out_valid=1, result stable until out_ready; out_valid & out_ready -> IDLE next cycle.
REQ-020 No new operand accepted in the cycle the result is consumed; in_ready rises the cycle after.
REQ-021 flush SHALL force IDLE, out_valid=0, result=0 next cycle; flush overrides in_valid and out_ready in the same cycle.
REQ-022 mode and data are sampled only at acceptance; later changes have no effect.
REQ-023 Maximum result is WIDTH; result bits above log2(WIDTH) are zero.

Reset
REQ-024 clrn low: state=IDLE, out_valid=0, busy=0, result=0, window=0, level=0, immediately and independent of clk.
REQ-025 Reset during RUN or DONE discards the operation; no result is delivered after release.
REQ-026 in_ready SHALL be 1 in the first cycle after clrn deasserts.

Configuration
REQ-027 Macro LCNT_EARLY_OUT_EN defined: at acceptance, an all-match operand (prepared window all zero) goes directly to DONE with result=WIDTH; out_valid in cycle 1.
REQ-028 Macro LCNT_EARLY_OUT_EN undefined: every operand takes the full log2(WIDTH)+1 latency; results identical in both builds.

Structure
REQ-029 Shared package lcnt_pkg SHALL hold the mode encodings (CLZ, CLO, CTZ, CTO) and the FSM state encodings.
REQ-030 Sub-module lcnt_prep (combinational bit-reverse plus conditional invert, parametrised by WIDTH) SHALL produce the initial window.
REQ-031 Level counter width SHALL be $clog2(WIDTH); no combinational path from data to result.

Verification (WIDTH=32, RES_W=32)
REQ-032 data=0xF1000000, mode=CLO -> result=4, out_valid 6 cycles after accept.
REQ-033 data=0x00000000, mode=CLZ -> result=32; cycle 1 with LCNT_EARLY_OUT_EN, cycle 6 without.
REQ-034 data=0x00000100, mode=CTZ -> 8; data=0x0000000F, mode=CTO -> 4; data=0x80000000, mode=CLZ -> 0.
REQ-035 out_ready held low 10 cycles in DONE -> result and out_valid stable, in_ready=0; out_ready pulse -> IDLE next cycle, in_ready=1 one cycle after the handshake.
REQ-036 flush asserted in RUN cycle 3 with in_valid=1 -> IDLE, out_valid never rises, operand not accepted; next operand completes normally.
REQ-037 clrn pulsed low mid-RUN -> all outputs 0 asynchronously, in_ready=1 the first cycle after release, no stale result delivered.
